// File: rtl/pc_next_pkg.sv
// Shared constants for the next-PC unit: redirect mode encodings and fetch step.
package pc_next_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_BRANCH = 2'b00;
    localparam mode_t MODE_JUMP   = 2'b01;
    localparam mode_t MODE_JR     = 2'b10;
    localparam mode_t MODE_EXC    = 2'b11;

    localparam int unsigned PC_STEP = 4;

endpackage : pc_next_pkg

// File: rtl/pc_next_unit_if.sv
// Redirect request bundle from decode/execute into the next-PC unit.
interface pc_next_unit_if
    import pc_next_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned REGION_W = 4,
    parameter int unsigned IMM_W    = 16
);
    localparam int unsigned TGT_W = ADDR_W - REGION_W - 2;

    logic              redirect_valid;
    mode_t             redirect_mode;
    logic [ADDR_W-1:0] branch_base;
    logic [IMM_W-1:0]  imm;
    logic [TGT_W-1:0]  target;
    logic [ADDR_W-1:0] jr_addr;

    modport master (
        output redirect_valid,
        output redirect_mode,
        output branch_base,
        output imm,
        output target,
        output jr_addr
    );

    modport slave (
        input redirect_valid,
        input redirect_mode,
        input branch_base,
        input imm,
        input target,
        input jr_addr
    );

endinterface : pc_next_unit_if

// File: rtl/pc_target_calc.sv
// Combinational redirect target: branch adder, region-jump combiner, JR alignment
// and exception vector, selected by the redirect mode.
module pc_target_calc
    import pc_next_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       REGION_W   = 4,
    parameter int unsigned       IMM_W      = 16,
    parameter logic [ADDR_W-1:0] EXC_VECTOR = 32'h0000_0080,
    localparam int unsigned      TGT_W      = ADDR_W - REGION_W - 2
) (
    input  mode_t             mode,
    input  logic [ADDR_W-1:0] branch_base,
    input  logic [IMM_W-1:0]  imm,
    input  logic [TGT_W-1:0]  target,
    input  logic [ADDR_W-1:0] jr_addr,
    output logic [ADDR_W-1:0] next_target_c,
    output logic              misaligned_c
);

    localparam int unsigned EXT_W = ADDR_W - IMM_W - 2;

    logic [ADDR_W-1:0] branch_off;
    logic [ADDR_W-1:0] branch_tgt;
    logic [ADDR_W-1:0] region_tgt;
    logic [ADDR_W-1:0] jr_tgt;

    // Word offset sign-extended and scaled to bytes in one concatenation.
    assign branch_off = {{EXT_W{imm[IMM_W-1]}}, imm, 2'b00};
    assign branch_tgt = branch_base + branch_off;
    assign region_tgt = {branch_base[ADDR_W-1 -: REGION_W], target, 2'b00};
    assign jr_tgt     = {jr_addr[ADDR_W-1:2], 2'b00};

    always_comb begin
        next_target_c = branch_tgt;
        misaligned_c  = 1'b0;
        case (mode)
            MODE_BRANCH: next_target_c = branch_tgt;
            MODE_JUMP:   next_target_c = region_tgt;
            MODE_JR: begin
                next_target_c = jr_tgt;
                misaligned_c  = |jr_addr[1:0];
            end
            MODE_EXC:    next_target_c = EXC_VECTOR;
            default:     next_target_c = branch_tgt;
        endcase
    end

endmodule : pc_target_calc

// File: rtl/pc_next_unit.sv
// Fetch PC register with sequential/redirect selection and a one-deep buffer
// that holds a redirect arriving under stall until fetch resumes.
module pc_next_unit
    import pc_next_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       REGION_W   = 4,
    parameter int unsigned       IMM_W      = 16,
    parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    pc_next_unit_if.slave     rdr,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              redirect_pending,
    output logic              misaligned_jr
);

    logic [ADDR_W-1:0] live_tgt;
    logic              live_mis;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] buf_tgt_q, buf_tgt_d;
    logic              buf_mis_q, buf_mis_d;
    logic              pending_q, pending_d;
    logic              mis_q, mis_d;

    pc_target_calc #(
        .ADDR_W     (ADDR_W),
        .REGION_W   (REGION_W),
        .IMM_W      (IMM_W),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_calc (
        .mode          (rdr.redirect_mode),
        .branch_base   (rdr.branch_base),
        .imm           (rdr.imm),
        .target        (rdr.target),
        .jr_addr       (rdr.jr_addr),
        .next_target_c (live_tgt),
        .misaligned_c  (live_mis)
    );

    // Next-state selection: live redirect beats the buffered one, which beats sequential.
    always_comb begin
        pc_d      = pc_q;
        buf_tgt_d = buf_tgt_q;
        buf_mis_d = buf_mis_q;
        pending_d = pending_q;
        mis_d     = 1'b0;
        if (!stall) begin
            if (rdr.redirect_valid) begin
                pc_d      = live_tgt;
                pending_d = 1'b0;
                mis_d     = live_mis;
            end else if (pending_q) begin
                pc_d      = buf_tgt_q;
                pending_d = 1'b0;
                mis_d     = buf_mis_q;
            end else begin
                pc_d      = pc_q + ADDR_W'(PC_STEP);
            end
        end else if (rdr.redirect_valid) begin
            buf_tgt_d = live_tgt;
            buf_mis_d = live_mis;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            buf_tgt_q <= '0;
            buf_mis_q <= 1'b0;
            pending_q <= 1'b0;
            mis_q     <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            buf_tgt_q <= buf_tgt_d;
            buf_mis_q <= buf_mis_d;
            pending_q <= pending_d;
            mis_q     <= mis_d;
        end
    end

    assign pc_out           = pc_q;
    assign pc_plus4         = pc_q + ADDR_W'(PC_STEP);
    assign redirect_pending = pending_q;
    assign misaligned_jr    = mis_q;

endmodule : pc_next_unit

// File: tb/tb_pc_next_unit.sv
// Vector-table bench for pc_next_unit: each applied cycle queues its expected
// state, which is popped and compared after the clock edge.
module tb_pc_next_unit;
    import pc_next_pkg::*;

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        valid;
        logic [1:0]  mode;
        logic [31:0] base;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] jr;
        logic [31:0] pc;
        logic        pend;
        logic        mis;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        pend;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        redirect_pending;
    logic        misaligned_jr;

    int checks = 0;
    int errors = 0;

    vec_t vecs[$];
    exp_t sb[$];

    pc_next_unit_if #(.ADDR_W(32), .REGION_W(4), .IMM_W(16)) rif ();

    pc_next_unit #(
        .ADDR_W(32), .REGION_W(4), .IMM_W(16),
        .RESET_PC(32'h0000_0000), .EXC_VECTOR(32'h0000_0080)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .rdr              (rif),
        .pc_out           (pc_out),
        .pc_plus4         (pc_plus4),
        .redirect_pending (redirect_pending),
        .misaligned_jr    (misaligned_jr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    function automatic vec_t v(logic r, logic s, logic vl, logic [1:0] m,
                               logic [31:0] b, logic [15:0] i, logic [25:0] t,
                               logic [31:0] j, logic [31:0] p, logic pd, logic ms);
        vec_t x;
        x.rst_n = r; x.stall = s; x.valid = vl; x.mode = m; x.base = b;
        x.imm = i; x.tgt = t; x.jr = j; x.pc = p; x.pend = pd; x.mis = ms;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input int idx);
        exp_t e;
        rst_n              = t.rst_n;
        stall              = t.stall;
        rif.redirect_valid = t.valid;
        rif.redirect_mode  = t.mode;
        rif.branch_base    = t.base;
        rif.imm            = t.imm;
        rif.target         = t.tgt;
        rif.jr_addr        = t.jr;
        sb.push_back('{t.pc, t.pend, t.mis});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty[%0d]: got 0 entries expected 1", idx);
        end else begin
            e = sb.pop_front();
            chk($sformatf("pc_out[%0d]", idx), pc_out, e.pc);
            chk($sformatf("pc_plus4[%0d]", idx), pc_plus4, e.pc + 32'd4);
            chk($sformatf("pending[%0d]", idx), 32'(redirect_pending), 32'(e.pend));
            chk($sformatf("misaligned[%0d]", idx), 32'(misaligned_jr), 32'(e.mis));
        end
    endtask

    initial begin
        //               rst stl vld mode          base           imm       tgt           jr             pc            pd  ms
        vecs.push_back(v(0, 0, 0, MODE_BRANCH, 32'h0,         16'h0,    26'h0,       32'h0,         32'h0,         0, 0));
        vecs.push_back(v(0, 0, 0, MODE_BRANCH, 32'h0,         16'h0,    26'h0,       32'h0,         32'h0,         0, 0));
        vecs.push_back(v(1, 0, 0, MODE_BRANCH, 32'h0,         16'h0,    26'h0,       32'h0,         32'h4,         0, 0));
        vecs.push_back(v(1, 0, 0, MODE_BRANCH, 32'h0,         16'h0,    26'h0,       32'h0,         32'h8,         0, 0));
        vecs.push_back(v(1, 0, 0, MODE_BRANCH, 32'h0,         16'h0,    26'h0,       32'h0,         32'hC,         0, 0));
        vecs.push_back(v(1, 0, 1, MODE_JUMP,   32'h9000_0014, 16'h0,    26'h0123456, 32'h0,         32'h9048_D158, 0, 0));
        vecs.push_back(v(1, 0, 0, MODE_BRANCH, 32'h0,         16'h0,    26'h0,       32'h0,         32'h9048_D15C, 0, 0));
        vecs.push_back(v(1, 0, 1, MODE_BRANCH, 32'h0040_0010, 16'hFFFC, 26'h0,       32'h0,         32'h0040_0000, 0, 0));
        vecs.push_back(v(1, 0, 0, MODE_BRANCH, 32'h0,         16'h0,    26'h0,       32'h0,         32'h0040_0004, 0, 0));
        // stalled redirect overwritten by a misaligned JR
        vecs.push_back(v(1, 0, 1, MODE_JR,     32'h0,         16'h0,    26'h0,       32'h0000_0100, 32'h0000_0100, 0, 0));
        vecs.push_back(v(1, 1, 1, MODE_BRANCH, 32'h0000_0200, 16'h0001, 26'h0,       32'h0,         32'h0000_0100, 1, 0));
        vecs.push_back(v(1, 1, 1, MODE_JR,     32'h0,         16'h0,    26'h0,       32'h0040_0006, 32'h0000_0100, 1, 0));
        vecs.push_back(v(1, 1, 0, MODE_BRANCH, 32'h0,         16'h0,    26'h0,       32'h0,         32'h0000_0100, 1, 0));
        vecs.push_back(v(1, 0, 0, MODE_BRANCH, 32'h0,         16'h0,    26'h0,       32'h0,         32'h0040_0004, 0, 1));
        vecs.push_back(v(1, 0, 0, MODE_BRANCH, 32'h0,         16'h0,    26'h0,       32'h0,         32'h0040_0008, 0, 0));
        // live exception beats buffered branch
        vecs.push_back(v(1, 1, 1, MODE_BRANCH, 32'h0000_02FC, 16'h0001, 26'h0,       32'h0,         32'h0040_0008, 1, 0));
        vecs.push_back(v(1, 0, 1, MODE_EXC,    32'h0,         16'h0,    26'h0,       32'h0,         32'h0000_0080, 0, 0));
        vecs.push_back(v(1, 0, 0, MODE_BRANCH, 32'h0,         16'h0,    26'h0,       32'h0,         32'h0000_0084, 0, 0));
        // reset while stalled with a pending redirect
        vecs.push_back(v(1, 1, 1, MODE_BRANCH, 32'h0000_0500, 16'h0,    26'h0,       32'h0,         32'h0000_0084, 1, 0));
        vecs.push_back(v(0, 1, 1, MODE_JR,     32'h0,         16'h0,    26'h0,       32'h0000_0701, 32'h0,         0, 0));
        vecs.push_back(v(1, 0, 0, MODE_BRANCH, 32'h0,         16'h0,    26'h0,       32'h0,         32'h4,         0, 0));
        vecs.push_back(v(1, 0, 0, MODE_BRANCH, 32'h0,         16'h0,    26'h0,       32'h0,         32'h8,         0, 0));
        // live misaligned JR to top of memory, then wrap to zero
        vecs.push_back(v(1, 0, 1, MODE_JR,     32'h0,         16'h0,    26'h0,       32'hFFFF_FFFF, 32'hFFFF_FFFC, 0, 1));
        vecs.push_back(v(1, 0, 0, MODE_BRANCH, 32'h0,         16'h0,    26'h0,       32'h0,         32'h0,         0, 0));
        vecs.push_back(v(1, 0, 0, MODE_BRANCH, 32'h0,         16'h0,    26'h0,       32'h0,         32'h4,         0, 0));
        vecs.push_back(v(1, 1, 0, MODE_BRANCH, 32'h0,         16'h0,    26'h0,       32'h0,         32'h4,         0, 0));
        // offset and field extremes
        vecs.push_back(v(1, 0, 1, MODE_BRANCH, 32'h0000_1000, 16'h7FFF, 26'h0,       32'h0,         32'h0002_0FFC, 0, 0));
        vecs.push_back(v(1, 0, 1, MODE_JUMP,   32'hF000_0000, 16'h0,    26'h3FFFFFF, 32'h0,         32'hFFFF_FFFC, 0, 0));
        vecs.push_back(v(1, 0, 1, MODE_BRANCH, 32'h0000_0004, 16'h8000, 26'h0,       32'h0,         32'hFFFE_0004, 0, 0));

        foreach (vecs[i]) apply(vecs[i], i);

        // Buffered misaligned JR: pulse lasts one cycle even when stall returns.
        apply(v(1, 1, 1, MODE_JR,     32'h0, 16'h0, 26'h0, 32'h0000_0013, 32'hFFFE_0004, 1, 0), 100);
        apply(v(1, 0, 0, MODE_BRANCH, 32'h0, 16'h0, 26'h0, 32'h0,         32'h0000_0010, 0, 1), 101);
        apply(v(1, 1, 0, MODE_BRANCH, 32'h0, 16'h0, 26'h0, 32'h0,         32'h0000_0010, 0, 0), 102);
        apply(v(1, 0, 0, MODE_BRANCH, 32'h0, 16'h0, 26'h0, 32'h0,         32'h0000_0014, 0, 0), 103);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pc_next_unit

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Parametrised successor to the fixed 4+28-bit jump-target combiner.
- Owns the fetch PC register and computes the next PC each cycle from one of these sources: sequential, branch, jump-region, jump-register or exception vector.
- Holds a redirect that arrives during a stall and applies it on the first unstalled cycle.
- Sits between decode/execute (redirect sources) and instruction memory (pc_out).

Parameters:
ADDR_W, 32, PC/address width.
REGION_W, 4, upper PC bits kept for region jumps; target field width TGT_W = ADDR_W-REGION_W-2.
IMM_W, 16, branch offset width (sign-extended, word offset).
RESET_PC, 32'h0000_0000, PC value after reset.
EXC_VECTOR, 32'h0000_0080, exception redirect target.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst_n  in  1  synchronous active-low reset.
stall  in  1  hold PC (fetch back-pressure).
redirect_valid  in  1  redirect request this cycle.
redirect_mode  in  2  00 branch, 01 jump-region, 10 jump-register, 11 exception.
branch_base  in  ADDR_W  PC+4 of the redirecting instruction.
imm  in  IMM_W  branch word offset.
target  in  TGT_W  jump target field.
jr_addr  in  ADDR_W  register jump address.
pc_out  out  ADDR_W  current fetch PC (registered).
pc_plus4  out  ADDR_W  pc_out+4 (combinational from register).
redirect_pending  out  1  a stalled redirect is buffered (registered).
misaligned_jr  out  1  one-cycle pulse: the applied JR target had nonzero bits [1:0] (registered).

Behaviour:
- Reset (rst_n=0 at edge): pc_out=RESET_PC, redirect_pending=0, buffered target cleared, misaligned_jr=0. Reset wins over every other input, including mid-stall with a redirect pending.
- Target calc (combinational, all arithmetic mod 2^ADDR_W):
  - branch = branch_base + (sext(imm) << 2).
  - jump-region = {branch_base[ADDR_W-1 -: REGION_W], target, 2'b00}.
  - jump-register = {jr_addr[ADDR_W-1:2], 2'b00}; misaligned flag = |jr_addr[1:0].
  - exception = EXC_VECTOR.
- Cycle rules, evaluated at each edge with rst_n=1:
  - stall=0, redirect_valid=1: pc_out <= live target; pending cleared. A live redirect beats a buffered one (latest wins).
  - stall=0, redirect_valid=0, pending=1: pc_out <= buffered target; pending <= 0.
  - stall=0, no redirect, no pending: pc_out <= pc_out+4. Wraps from 0xFFFF_FFFC to 0.
  - stall=1, redirect_valid=1: pc_out holds; buffer <= live target (overwrites any older buffered target); pending <= 1.
  - stall=1, no redirect: pc_out and buffer hold.
- Latency: a redirect accepted at edge N appears on pc_out after edge N; a stalled redirect appears after the first edge with stall=0.
- misaligned_jr:
  - Set to 1 for exactly one cycle after the edge at which a misaligned jump-register target is loaded into pc_out, whether live or from the buffer.
  - The misaligned bit is buffered with the target.
  - 0 otherwise.
- Redirect modes are exclusive, so there is no priority among modes; the exception mode takes the same path as the others.
- No X propagation: when redirect_valid=0, redirect_mode/imm/target/jr_addr are don't-care.

Decomposition:
- Package pc_next_pkg: redirect_mode localparams (MODE_BRANCH=2'b00, MODE_JUMP=2'b01, MODE_JR=2'b10, MODE_EXC=2'b11), PC_STEP=4.
- Sub-module pc_target_calc: purely combinational, the generalised region combiner plus the branch adder and JR alignment.
  - Inputs: mode, branch_base, imm, target, jr_addr.
  - Outputs: next target and misaligned flag.
  - Parametrised by ADDR_W/REGION_W/IMM_W/EXC_VECTOR.
- Top holds pc register, pending buffer and flag registers.

Test Plan:
1. Reset and sequential fetch: rst_n=0 for 2 cycles, then release with stall=0. Required: pc_out=0x0 during reset, then 0x4, 0x8, 0xC; pending=0.
2. Jump-region: branch_base=0x9000_0014, target=26'h0123456, mode=01, one cycle. Required: next pc_out=0x9048_D158; following cycle 0x9048_D15C.
3. Backward branch: branch_base=0x0040_0010, imm=16'hFFFC, mode=00. Required: pc_out=0x0040_0000.
4. Stalled redirect with overwrite:
   - Setup: stall=1 while pc=0x100. Branch to base 0x200, imm 1, giving 0x204. Next cycle, still stalled, jump-register jr_addr=0x0040_0006.
   - During the stall: pc stays 0x100 and pending=1.
   - On release: pc=0x0040_0004, misaligned_jr=1 for one cycle, pending=0.
5. Live versus pending:
   - Setup: pending branch target 0x300 buffered. In the release cycle, mode=11 is live.
   - Required: pc=EXC_VECTOR 0x80, pending cleared, next 0x84.
6. Reset mid-stall with pending=1: rst_n=0 for one edge. Required: pc=RESET_PC, pending=0; after release, pc increments from 0x0 and the old target is never fetched.
